// File: rtl/board_refill.sv
// board_refill: drops surviving tiles to the bottom of each column of an
// 8x8 board, then tops each column up with LFSR-generated colours.
// One cell is visited per clock: 8 compaction cycles then 8 fill cycles per
// column, so every run takes exactly 128 cycles regardless of content.
module board_refill #(
    parameter int          NUM_COLORS = 5,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [191:0] board_in,
    output logic         busy,
    output logic         done,
    output logic [191:0] board_out,
    output logic [6:0]   fill_count
);

    // An all-zero seed would lock the LFSR, so it is swapped for the default.
    localparam logic [15:0] LFSR_INIT = (SEED == 16'h0000) ? 16'hACE1 : SEED;

    typedef enum logic [1:0] {IDLE, COMPACT, FILL} state_t;

    state_t            state, state_next;
    logic [2:0]        step;
    logic [2:0]        col;
    logic signed [3:0] wptr, wptr_next;
    logic [15:0]       lfsr, lfsr_next;
    logic [191:0]      work, work_next;
    logic [6:0]        fills, fills_next;
    logic [2:0]        row;
    logic [2:0]        cell_val;
    logic [2:0]        v;
    logic [2:0]        colour;
    logic [7:0]        rd_base, wr_base, fill_base;
    logic              last_step, last_col, fill_en;

    function automatic logic [7:0] cell_base(input logic [2:0] x, input logic [2:0] y);
        return {2'b00, y, x} * 8'd3;
    endfunction

    // The same step counter walks rows bottom-up while compacting and
    // top-down while filling.
    assign row       = 3'd7 - step;
    assign last_step = (step == 3'd7);
    assign last_col  = (col == 3'd7);
    assign rd_base   = cell_base(col, row);
    assign wr_base   = cell_base(col, wptr[2:0]);
    assign fill_base = cell_base(col, step);
    assign cell_val  = work[rd_base +: 3];
    assign fill_en   = ($signed({1'b0, step}) <= wptr);

    // Map the low LFSR bits onto a legal colour 1..NUM_COLORS.
    always_comb begin
        v = lfsr[2:0];
        if (int'(v) >= NUM_COLORS) begin
            v = v - 3'(NUM_COLORS);
        end
        colour = v + 3'd1;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: 8 compaction cycles, 8 fill cycles, repeat per column.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = COMPACT;
                end
            end
            COMPACT: begin
                if (last_step) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                if (last_step) begin
                    state_next = last_col ? IDLE : COMPACT;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode from the state.
    always_comb begin
        busy = (state != IDLE);
    end

    // Datapath next values: tile moves during compaction, colour writes during fill.
    always_comb begin
        work_next  = work;
        wptr_next  = wptr;
        lfsr_next  = lfsr;
        fills_next = fills;
        case (state)
            IDLE: begin
                if (start) begin
                    work_next  = board_in;
                    wptr_next  = 4'sd7;
                    fills_next = 7'd0;
                end
            end
            COMPACT: begin
                if (cell_val != 3'd0) begin
                    work_next[wr_base +: 3] = cell_val;
                    wptr_next               = wptr - 4'sd1;
                end
            end
            FILL: begin
                if (fill_en) begin
                    work_next[fill_base +: 3] = colour;
                    lfsr_next  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                    fills_next = fills + 7'd1;
                end
                if (last_step) begin
                    wptr_next = 4'sd7;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers and the completion publish of the finished board.
    always_ff @(posedge clk) begin
        if (rst) begin
            step       <= 3'd0;
            col        <= 3'd0;
            wptr       <= 4'sd7;
            lfsr       <= LFSR_INIT;
            work       <= '0;
            fills      <= 7'd0;
            board_out  <= '0;
            fill_count <= 7'd0;
            done       <= 1'b0;
        end else begin
            work  <= work_next;
            wptr  <= wptr_next;
            lfsr  <= lfsr_next;
            fills <= fills_next;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        step <= 3'd0;
                        col  <= 3'd0;
                    end
                end
                COMPACT: begin
                    step <= step + 3'd1;
                end
                FILL: begin
                    step <= step + 3'd1;
                    if (last_step) begin
                        if (last_col) begin
                            board_out  <= work_next;
                            fill_count <= fills_next;
                            done       <= 1'b1;
                        end else begin
                            col <= col + 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_board_refill.sv
// Testbench for board_refill: directed table, hand-written corner sequences
// and randomized boards checked against a column-by-column reference model.
module tb_board_refill;

    localparam int          NUM_COLORS = 5;
    localparam logic [15:0] SEED       = 16'hACE1;

    // Column 0 of the gravity case, packed y7..y0 so [y*3 +: 3] selects row y.
    localparam logic [23:0] G_IN  = {3'd1, 3'd5, 3'd0, 3'd4, 3'd3, 3'd0, 3'd2, 3'd1};
    localparam logic [23:0] G_OUT = {3'd1, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd4, 3'd2};

    typedef struct {
        string        name;
        logic [191:0] board;
        logic [191:0] exp_board;
        int           exp_fill;
        bit           use_model;
    } vec_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic [191:0] board_in;
    logic         busy;
    logic         done;
    logic [191:0] board_out;
    logic [6:0]   fill_count;

    int           checks;
    int           errors;
    logic [15:0]  model_lfsr;
    vec_t         vecs[4];
    logic [191:0] pattern_board, gravity_in, gravity_out;
    logic [191:0] res, m_res, exp_b, rnd_board;
    logic [6:0]   fc;
    int           m_fc, exp_f, bad;

    board_refill #(
        .NUM_COLORS(NUM_COLORS),
        .SEED      (SEED)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .board_in  (board_in),
        .busy      (busy),
        .done      (done),
        .board_out (board_out),
        .fill_count(fill_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] getCell(input logic [191:0] b, input int x, input int y);
        return b[(y * 8 + x) * 3 +: 3];
    endfunction

    // Reference colour source: next colour in fill order, then step the LFSR.
    function automatic logic [2:0] modelColour();
        logic [2:0] c;
        c = 3'((int'(model_lfsr[2:0]) % NUM_COLORS) + 1);
        model_lfsr = {model_lfsr[14:0], ^(model_lfsr & 16'hB400)};
        return c;
    endfunction

    // Reference refill: surviving tiles keep their order at the bottom,
    // vacated top cells take fresh colours column by column, top first.
    function automatic void modelRun(input logic [191:0] b, output logic [191:0] r, output int f);
        logic [2:0] tiles[$];
        int         k;
        r = '0;
        f = 0;
        for (int x = 0; x < 8; x++) begin
            tiles.delete();
            for (int y = 0; y < 8; y++) begin
                if (getCell(b, x, y) != 3'd0) tiles.push_back(getCell(b, x, y));
            end
            k = 8 - tiles.size();
            for (int y = 0; y < k; y++) begin
                r[(y * 8 + x) * 3 +: 3] = modelColour();
                f++;
            end
            for (int y = k; y < 8; y++) begin
                r[(y * 8 + x) * 3 +: 3] = tiles[y - k];
            end
        end
    endfunction

    task automatic checkOutput(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic doReset(input int n);
        @(negedge clk);
        rst      = 1'b1;
        start    = 1'b1;
        board_in = pattern_board;
        repeat (n) @(negedge clk);
        checkOutput("reset_busy", 192'(busy), 192'(0));
        checkOutput("reset_done", 192'(done), 192'(0));
        checkOutput("reset_board_out", board_out, '0);
        checkOutput("reset_fill_count", 192'(fill_count), 192'(0));
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checkOutput("start_during_reset_ignored", 192'(busy), 192'(0));
        model_lfsr = SEED;
    endtask

    // Launch one run and wait (bounded) for done; checks latency, busy and
    // output stability. chained starts in the current cycle (back-to-back),
    // interfere_at pulses a second start mid-run, tail checks done drops.
    task automatic applyStimulus(input logic [191:0] b, input bit chained, input int interfere_at,
                                 input logic [191:0] other, input bit tail,
                                 output logic [191:0] r, output logic [6:0] f);
        int           cycles;
        bit           busy_bad;
        bit           out_moved;
        logic [191:0] held;
        if (!chained) @(negedge clk);
        board_in = b;
        start    = 1'b1;
        held     = board_out;
        @(negedge clk);
        start     = 1'b0;
        cycles    = 0;
        busy_bad  = 1'b0;
        out_moved = 1'b0;
        while (!done && cycles < 300) begin
            if (!busy) busy_bad = 1'b1;
            if (board_out !== held) out_moved = 1'b1;
            @(negedge clk);
            cycles++;
            start = (cycles == interfere_at);
            if (start) board_in = other;
        end
        start = 1'b0;
        checkOutput("latency", 192'(cycles), 192'(128));
        checkOutput("busy_during_run", 192'(busy_bad), 192'(0));
        checkOutput("board_out_stable", 192'(out_moved), 192'(0));
        checkOutput("busy_at_done", 192'(busy), 192'(0));
        r = board_out;
        f = fill_count;
        if (tail) begin
            @(negedge clk);
            checkOutput("done_single_cycle", 192'(done), 192'(0));
        end
    endtask

    task automatic setVec(input int i, input string name, input logic [191:0] b,
                          input logic [191:0] e, input int f, input bit m);
        vecs[i].name      = name;
        vecs[i].board     = b;
        vecs[i].exp_board = e;
        vecs[i].exp_fill  = f;
        vecs[i].use_model = m;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b0;
        start    = 1'b0;
        board_in = '0;

        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 8; x++) begin
                pattern_board[(y * 8 + x) * 3 +: 3] = 3'(((x + y) % 5) + 1);
                gravity_in[(y * 8 + x) * 3 +: 3]    = (x == 0) ? G_IN[y * 3 +: 3] : 3'd3;
                gravity_out[(y * 8 + x) * 3 +: 3]   = (x == 0) ? G_OUT[y * 3 +: 3] : 3'd3;
            end
        end

        doReset(2);

        setVec(0, "no_empties", pattern_board, pattern_board, 0, 1'b0);
        setVec(1, "gravity_col0", gravity_in, gravity_out, 2, 1'b0);
        setVec(2, "no_empties_again", pattern_board, pattern_board, 0, 1'b0);
        setVec(3, "empty_board", '0, '0, 64, 1'b1);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i].board, 1'b0, -1, '0, 1'b1, res, fc);
            modelRun(vecs[i].board, m_res, m_fc);
            if (vecs[i].use_model) begin
                exp_b = m_res;
                exp_f = m_fc;
            end else begin
                exp_b = vecs[i].exp_board;
                exp_f = vecs[i].exp_fill;
            end
            checkOutput({vecs[i].name, "_board"}, res, exp_b);
            checkOutput({vecs[i].name, "_fill"}, 192'(fc), 192'(exp_f));
            if (vecs[i].board == '0) begin
                bad = 0;
                for (int c = 0; c < 64; c++) begin
                    if (res[c * 3 +: 3] == 3'd0 || int'(res[c * 3 +: 3]) > NUM_COLORS) bad++;
                end
                checkOutput("empty_board_colour_range", 192'(bad), 192'(0));
            end
        end

        // Start pulse while busy must not disturb the run in progress.
        doReset(1);
        applyStimulus(gravity_in, 1'b0, 40, '0, 1'b1, res, fc);
        modelRun(gravity_in, m_res, m_fc);
        checkOutput("start_while_busy_board", res, gravity_out);
        checkOutput("start_while_busy_fill", 192'(fc), 192'(2));

        // Reset in the middle of a run aborts it and restores the seed.
        @(negedge clk);
        board_in = gravity_in;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (60) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrun_reset_busy", 192'(busy), 192'(0));
        checkOutput("midrun_reset_done", 192'(done), 192'(0));
        checkOutput("midrun_reset_board_out", board_out, '0);
        checkOutput("midrun_reset_fill_count", 192'(fill_count), 192'(0));
        rst        = 1'b0;
        model_lfsr = SEED;
        applyStimulus(gravity_in, 1'b0, -1, '0, 1'b1, res, fc);
        modelRun(gravity_in, m_res, m_fc);
        checkOutput("after_reset_rerun_board", res, gravity_out);
        checkOutput("after_reset_rerun_fill", 192'(fc), 192'(2));

        // Randomized boards; every fourth run starts in the done cycle of the previous.
        for (int i = 0; i < 16; i++) begin
            for (int c = 0; c < 64; c++) begin
                if ($urandom_range(0, 9) < ((i % 3 == 0) ? 7 : 3)) begin
                    rnd_board[c * 3 +: 3] = 3'd0;
                end else begin
                    rnd_board[c * 3 +: 3] = 3'($urandom_range(1, 7));
                end
            end
            applyStimulus(rnd_board, (i % 4 == 1), -1, '0, ((i + 1) % 4 != 1), res, fc);
            modelRun(rnd_board, m_res, m_fc);
            checkOutput("random_board", res, m_res);
            checkOutput("random_fill", 192'(fc), 192'(m_fc));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
